logic16_pipe: RTL and testbench
===============================

Name: logic16_pipe

Overview:
- Two-stage registered 16-bit bitwise logic unit with valid/ready handshakes on both sides.
- Stage 1 captures operands and opcode from the upstream operand source.
- Stage 2 evaluates AND/OR/XOR/NOT using the gate-level and16 instance plus sibling gate vectors, then registers the result and flags for the ALU result mux.
- Sits between the register-file read port and the ALU writeback mux.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported, because it is bound to and16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents a valid operand set
- in_ready  output  1  block accepts the operand set this cycle
- in_a  input  16  operand A
- in_b  input  16  operand B
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 NOT A (in_b ignored)
- out_valid  output  1  result registered and valid
- out_ready  input  1  downstream consumes the result this cycle
- out_result  output  16  registered logic result
- out_zero  output  1  out_result == 16'h0000
- out_neg  output  1  out_result[15]
- inflight  output  2  number of valid stages (0..2)

Behaviour:
- Reset: rst_n low clears all outputs asynchronously and immediately. out_valid=0, out_result=0, out_zero=0, out_neg=0, inflight=0, all stage-1 registers=0. in_ready reads 1 while held in reset. Release takes effect on the first clk edge after rst_n rises.
- Handshake: a transfer occurs on a clk edge where valid&&ready. Once asserted, in_valid and its payload must stay stable until accepted. out_valid, out_result and the flags stay stable until out_ready is high.
- Pipeline: s2_adv = !out_valid || out_ready; in_ready = !s1_valid || s2_adv. in_ready depends combinationally on out_ready. No other combinational input-to-output path exists.
- Edge actions:
  - If s2_adv, stage 2 loads s1_valid, f(s1_op, s1_a, s1_b) and the flags derived from that value.
  - If in_ready, stage 1 loads in_valid, in_a, in_b, in_op.
  - When a valid stage is loaded with valid=0, its data registers hold their previous values.
- Latency: 2 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 per cycle.
- Stall: with out_ready=0 and both stages full, in_ready=0 and nothing changes. A third operand set waits upstream.
- Simultaneous events: when out_ready=1 and both stages are full, stage 1 moves to stage 2 and a new input is accepted on the same edge. No bubble is inserted.
- inflight = s1_valid + out_valid, registered alongside the stages.
- Flags are computed from the new result at stage-2 load, never from the held value.
- Reset mid-operation discards both stages. No partial result is ever presented.
- Unused in_b for op 11 has no effect on any output.

Optional Feature:
- Macro: LOGIC16_PARITY_EN
- Defined: adds output out_parity (1 bit) = XOR-reduce of out_result (even parity bit). It is registered in stage 2 with the other flags and resets to 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with both stages full -> out_valid=0, inflight=0, out_result=16'h0000 immediately, with no clk edge required.
- Streaming: out_ready=1; send AND A=F0F0 B=FF00, OR 0F0F/00F0, XOR AAAA/5555, NOT A=FFFF back-to-back. Required outputs, one per cycle starting 2 cycles after the first accept:
  - F000, neg=1
  - 0FFF
  - FFFF, neg=1
  - 0000, zero=1
- Backpressure: out_ready=0; offer 3 sets -> first 2 accepted, in_ready=0, inflight=2. The 3rd is held until out_ready=1. Results then appear in order with none lost or duplicated.
- Simultaneous pop/push: both stages full, out_ready=1 and in_valid=1 on the same edge -> the output advances, the new set is accepted, and inflight stays 2.
- Random: 10k random ops with random in_valid/out_ready, checked against a scoreboard model. Required: exact order, exact values, flags correct.
- With LOGIC16_PARITY_EN defined: XOR 0001/0000 -> out_result=0001, out_parity=1. XOR 0003/0000 -> out_parity=0.

Source files
------------

// File: rtl/logic16_pipe.sv
// Two-stage registered 16-bit bitwise logic unit (AND/OR/XOR/NOT A) with valid/ready on both sides.
// Optional even-parity output out_parity is enabled by defining LOGIC16_PARITY_EN.

module and16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  for (genvar i = 0; i < 16; i++) begin : g_bit
    and u_and (y[i], a[i], b[i]);
  end

endmodule

module logic16_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic [1:0]       inflight
`ifdef LOGIC16_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;

  logic             s2_adv;
  logic             s1_valid_next;
  logic             s2_valid_next;

  logic [WIDTH-1:0] and_vec;
  logic [WIDTH-1:0] or_vec;
  logic [WIDTH-1:0] xor_vec;
  logic [WIDTH-1:0] not_vec;
  logic [WIDTH-1:0] result_next;

  // Stage 2 may load whenever its slot is empty or being drained this cycle.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  assign s1_valid_next = in_ready ? in_valid : s1_valid;
  assign s2_valid_next = s2_adv ? s1_valid : out_valid;

  // AND comes from the shared gate-level block; the other ops are sibling gate vectors.
  and16 u_and16 (
    .a (s1_a),
    .b (s1_b),
    .y (and_vec)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_gates
    or  u_or  (or_vec[i],  s1_a[i], s1_b[i]);
    xor u_xor (xor_vec[i], s1_a[i], s1_b[i]);
    not u_not (not_vec[i], s1_a[i]);
  end

  always_comb begin
    result_next = and_vec;
    case (s1_op)
      OP_AND:  result_next = and_vec;
      OP_OR:   result_next = or_vec;
      OP_XOR:  result_next = xor_vec;
      OP_NOT:  result_next = not_vec;
      default: result_next = and_vec;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= 2'b00;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= in_op;
      end
    end
  end

  // Flags are derived from the value being loaded, so they always match out_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result_next;
        out_zero   <= (result_next == '0);
        out_neg    <= result_next[WIDTH-1];
      end
    end
  end

`ifdef LOGIC16_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      out_parity <= ^result_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 2'd0;
    end else begin
      inflight <= {1'b0, s1_valid_next} + {1'b0, s2_valid_next};
    end
  end

endmodule

// File: tb/tb_logic16_pipe.sv
// Self-checking bench for logic16_pipe: directed streaming, backpressure, reset and random traffic
// against a queue-based scoreboard.

module tb_logic16_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_neg;
  logic [1:0]  inflight;
`ifdef LOGIC16_PARITY_EN
  logic        out_parity;
`endif

  typedef struct {
    logic [15:0] result;
    int          cyc;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [15:0] drive_exp;
  int          vectors;
  int          miscompares;
  int          neg_cnt;
  bit          lat_check;

  logic16_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .inflight   (inflight)
`ifdef LOGIC16_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Scoreboard: push on accept, pop and compare on consume; both sampled mid-cycle.
  always @(negedge clk) begin
    neg_cnt++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 32'(out_result), 32'hDEAD_0000);
        end else begin
          sb_entry_t e;
          e = sb.pop_front();
          checkOutput("result", 32'(out_result), 32'(e.result));
          checkOutput("zero", 32'(out_zero), 32'(e.result == 16'h0000));
          checkOutput("neg", 32'(out_neg), 32'(e.result[15]));
`ifdef LOGIC16_PARITY_EN
          checkOutput("parity", 32'(out_parity), 32'(^e.result));
`endif
          if (lat_check) checkOutput("latency", 32'(neg_cnt - e.cyc), 32'd2);
        end
      end
      if (in_valid && in_ready) sb.push_back('{result: drive_exp, cyc: neg_cnt});
    end
  end

  // Called at posedge+1; holds the set until accepted, returns at the posedge+1 after acceptance.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                               input logic [15:0] exp);
    bit taken;
    taken     = 1'b0;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    drive_exp = exp;
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    checkOutput("drain_left", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("drain_inflight", 32'(inflight), 32'd0);
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit          took;
    int          sent;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rop;

    vectors     = 0;
    miscompares = 0;
    neg_cnt     = 0;
    lat_check   = 1'b0;
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_a        = 16'h0;
    in_b        = 16'h0;
    in_op       = 2'b00;
    drive_exp   = 16'h0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_inflight", 32'(inflight), 32'd0);
    checkOutput("rst_result", 32'(out_result), 32'd0);
    checkOutput("rst_zero", 32'(out_zero), 32'd0);
    checkOutput("rst_neg", 32'(out_neg), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] streaming");
    out_ready = 1'b1;
    lat_check = 1'b1;
    applyStimulus(16'hF0F0, 16'hFF00, 2'b00, 16'hF000);
    applyStimulus(16'h0F0F, 16'h00F0, 2'b01, 16'h0FFF);
    applyStimulus(16'hAAAA, 16'h5555, 2'b10, 16'hFFFF);
    applyStimulus(16'hFFFF, 16'h1234, 2'b11, 16'h0000);
    in_valid = 1'b0;
    drain();
    lat_check = 1'b0;

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h00FF, 2'b00, 16'h0034);
    applyStimulus(16'h8000, 16'h0001, 2'b01, 16'h8001);
    in_a      = 16'h0F0F;
    in_b      = 16'hFFFF;
    in_op     = 2'b10;
    drive_exp = 16'hF0F0;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_inflight", 32'(inflight), 32'd2);
      checkOutput("bp_out_result", 32'(out_result), 32'h0034);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("pp_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("pp_inflight", 32'(inflight), 32'd2);
    checkOutput("pp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("pp_out_result", 32'(out_result), 32'h8001);
    drain();

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(16'hFFFF, 16'hFFFF, 2'b00, 16'hFFFF);
    applyStimulus(16'h0001, 16'h0002, 2'b01, 16'h0003);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_inflight", 32'(inflight), 32'd2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_inflight", 32'(inflight), 32'd0);
    checkOutput("mid_rst_result", 32'(out_result), 32'd0);
    checkOutput("mid_rst_neg", 32'(out_neg), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

`ifdef LOGIC16_PARITY_EN
    $display("[TB] parity");
    applyStimulus(16'h0001, 16'h0000, 2'b10, 16'h0001);
    applyStimulus(16'h0003, 16'h0000, 2'b10, 16'h0003);
    in_valid = 1'b0;
    drain();
`endif

    $display("[TB] random");
    took = 1'b0;
    sent = 0;
    while (sent < 10000) begin
      @(posedge clk);
      #1;
      if (took) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        ra        = 16'($urandom);
        rb        = 16'($urandom);
        rop       = 2'($urandom_range(0, 3));
        in_a      = ra;
        in_b      = rb;
        in_op     = rop;
        drive_exp = model(ra, rb, rop);
        in_valid  = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) sent++;
    end
    @(posedge clk);
    #1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
